scatter_ctrl: RTL and testbench
===============================

Name: scatter_ctrl

Overview:
- Sequencer for the `scatter` datapath.
- Holds one packed input block of up to IN elements and issues its elements into free downstream slots over one or more cycles.
- Drives the scatter's `offset` and `sel` inputs so the block drains in order.
- Pops the block upstream once every element has been placed.
- Sits between an input block queue and an OUT-slot buffer that reports its free slots each cycle.

Parameters:
- DATA, 32, element width; passed through for instantiation consistency, not used in control logic.
- IN, 8, maximum elements per input block.
- OUT, 16, number of downstream slots.
- ACT, `High, polarity of `slot_free` and `sel`: `Enable` when ACT is high, `Enable_` otherwise.
- OFS, $clog2(IN), width of `offset`.
- CNT, $clog2(IN+1), width of the element counts.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- in_valid  in  1  input block present; `in_num` must stay stable until `in_ready`.
- in_num  in  CNT  valid elements in the block (0..IN); values above IN are clamped to IN.
- in_ready  out  1  block fully issued this cycle; upstream pops it.
- slot_free  in  OUT  per-slot free flag, ACT polarity.
- stall  in  1  downstream hold; nothing issues while it is asserted.
- flush  in  1  abandon the current block.
- offset  out  OFS  index of the next unissued element; connects to scatter `offset`.
- sel  out  OUT  slots receiving elements this cycle, ACT polarity; connects to scatter `sel`.
- issue_num  out  CNT  number of elements issued this cycle.
- busy  out  1  a block is partially issued (FSM in PART).

Behaviour:
- State: FSM {IDLE, PART} plus the `offset` register.
  - IDLE implies offset == 0.
  - PART implies 0 < offset < in_num.
- Reset values (synchronous; applied whenever reset is sampled high):
  - offset = 0, state = IDLE.
  - While reset is high, combinational outputs are forced: sel = all DISABLE, in_ready = 0, issue_num = 0, busy = 0.
- Per-cycle computation, combinational from the registers and the inputs:
  - num = min(in_num, IN).
  - avail = num - offset.
  - free = popcount of slots where slot_free == ENABLE.
  - take = (in_valid && !stall && !flush) ? min(avail, free) : 0.
  - sel = ENABLE on the `take` lowest-indexed free slots; DISABLE everywhere else.
  - issue_num = take.
  - in_ready = in_valid && !stall && !flush && (offset + take == num).
- Issue latency: zero. `sel` and `in_ready` are valid in the same cycle as `slot_free`; the scatter output is valid in that same cycle.
- Register update on each clock edge:
  - flush: offset <= 0, state <= IDLE. `in_ready` is not asserted and the block is not popped. Flush has priority over issue.
  - in_ready: offset <= 0, state <= IDLE.
  - take > 0 without completing the block: offset <= offset + take, state <= PART.
  - otherwise: hold.
- Boundaries:
  - in_num == 0 with in_valid: in_ready = 1 immediately, sel all DISABLE, take = 0.
  - free == 0 or stall: no progress, offset held, in_ready = 0.
  - free >= avail: the block completes this cycle; surplus free slots stay DISABLE.
  - in_valid dropped while in PART: protocol violation. take = 0 and offset holds. Only flush or reset recovers.
  - Back-to-back blocks: after an in_ready cycle the next block starts at offset 0 on the next cycle, with no bubble.
  - offset never reaches num in a registered state, because completion returns it to 0, so there is no wrap-around.
- Invariant: the scatter `valid` output of slot k equals `sel[k]` whenever the controller drives the scatter.

Test Plan (IN=8, OUT=16, ACT=High):
- in_valid=1, in_num=3, slot_free=0x0023:
  - sel=0x0023, issue_num=3, offset=0, in_ready=1 in the same cycle.
  - Next cycle: busy=0.
- in_num=8; cycle 1 slot_free=0x000F, cycle 2 slot_free=0x00F0:
  - Cycle 1: sel=0x000F, issue_num=4, in_ready=0.
  - Cycle 2: offset=4, busy=1, sel=0x00F0, in_ready=1.
  - Cycle 3: offset=0.
- in_num=5, slot_free=0xFFFF:
  - sel=0x001F, issue_num=5, in_ready=1.
  - Slots 5..15 remain DISABLE.
- Hold conditions:
  - Block in PART (offset=4) with slot_free=0x0000 for 3 cycles: sel=0, offset stays 4, in_ready=0.
  - Then stall=1 with slot_free=0xFFFF: same hold.
- Abort paths:
  - flush=1 with offset=4: next cycle offset=0, busy=0, and no in_ready pulse.
  - reset=1 with offset=4: next cycle offset=0, busy=0, and no in_ready pulse.
  - While reset is high, all outputs are at their reset values.
- Edge cases:
  - in_num=0: in_ready=1 and sel=0 in the same cycle.
  - in_num=12: clamped to 8, so slot_free=0xFFFF gives sel=0x00FF.
- Random regression: 1000 cycles of random slot_free, stall and in_num, checked against a scoreboard model of the offset and popcount rules.

Source files
------------

// File: rtl/scatter_ctrl.sv
// Sequencer for the scatter datapath: drains one packed input block into the
// free downstream slots in element order, popping the block once fully placed.
module scatter_ctrl #(
  parameter int DATA = 32,
  parameter int IN   = 8,
  parameter int OUT  = 16,
  parameter bit ACT  = 1'b1,
  parameter int OFS  = $clog2(IN),
  parameter int CNT  = $clog2(IN + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [CNT-1:0] in_num,
  output logic           in_ready,
  input  logic [OUT-1:0] slot_free,
  input  logic           stall,
  input  logic           flush,
  output logic [OFS-1:0] offset,
  output logic [OUT-1:0] sel,
  output logic [CNT-1:0] issue_num,
  output logic           busy
);

  localparam int FW = $clog2(OUT + 1);
  localparam int TW = (CNT > FW) ? CNT : FW;

  // DATA only rides along for instantiation consistency; reject nonsense sizes.
  if (DATA < 1 || IN < 2 || OUT < 1) begin : g_param_check
    $error("scatter_ctrl: DATA >= 1, IN >= 2 and OUT >= 1 are required");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PART = 1'b1
  } state_t;

  state_t         state_r;
  logic [OFS-1:0] offset_r;

  logic [CNT-1:0] num_s;
  logic [CNT-1:0] ofs_ext_s;
  logic [CNT-1:0] avail_s;
  logic [FW-1:0]  free_s;
  logic [CNT-1:0] take_s;
  logic           go_s;
  logic           done_s;
  logic [OUT-1:0] sel_s;
  logic [TW-1:0]  cnt_s;

  // Clamp the block size, count free slots and size this cycle's issue.
  always_comb begin
    num_s     = (in_num > CNT'(IN)) ? CNT'(IN) : in_num;
    ofs_ext_s = CNT'(offset_r);
    avail_s   = (num_s > ofs_ext_s) ? (num_s - ofs_ext_s) : {CNT{1'b0}};
    free_s    = {FW{1'b0}};
    for (int k = 0; k < OUT; k++) begin
      if (slot_free[k] == ACT) begin
        free_s = free_s + FW'(1'b1);
      end else begin
        free_s = free_s;
      end
    end
    go_s = in_valid && !stall && !flush;
    if (go_s) begin
      take_s = (TW'(avail_s) <= TW'(free_s)) ? avail_s : CNT'(free_s);
    end else begin
      take_s = {CNT{1'b0}};
    end
    done_s = go_s && ((ofs_ext_s + take_s) == num_s);
  end

  // Enable the take lowest-indexed free slots; surplus free slots stay disabled.
  always_comb begin
    sel_s = {OUT{~ACT}};
    cnt_s = {TW{1'b0}};
    for (int k = 0; k < OUT; k++) begin
      if ((slot_free[k] == ACT) && (cnt_s < TW'(take_s))) begin
        sel_s[k] = ACT;
        cnt_s    = cnt_s + TW'(1'b1);
      end else begin
        sel_s[k] = ~ACT;
      end
    end
  end

  // Block FSM and drain offset; flush outranks completion, completion outranks progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      offset_r <= {OFS{1'b0}};
    end else if (flush) begin
      state_r  <= IDLE;
      offset_r <= {OFS{1'b0}};
    end else if (done_s) begin
      state_r  <= IDLE;
      offset_r <= {OFS{1'b0}};
    end else if (take_s != {CNT{1'b0}}) begin
      state_r  <= PART;
      offset_r <= offset_r + OFS'(take_s);
    end else begin
      state_r  <= state_r;
      offset_r <= offset_r;
    end
  end

  // Outputs sit at their idle values for as long as reset is high.
  always_comb begin
    if (reset) begin
      sel       = {OUT{~ACT}};
      in_ready  = 1'b0;
      issue_num = {CNT{1'b0}};
      busy      = 1'b0;
      offset    = {OFS{1'b0}};
    end else begin
      sel       = sel_s;
      in_ready  = done_s;
      issue_num = take_s;
      busy      = (state_r == PART);
      offset    = offset_r;
    end
  end

endmodule

// File: tb/tb_scatter_ctrl.sv
// Bench for scatter_ctrl (IN=8, OUT=16, ACT high): directed vector table,
// a walking-slot drain sequence, and a randomized run against a reference model.
module tb_scatter_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_num;
  logic        in_ready;
  logic [15:0] slot_free;
  logic        stall;
  logic        flush;
  logic [2:0]  offset;
  logic [15:0] sel;
  logic [3:0]  issue_num;
  logic        busy;

  int compared;
  int mismatched;

  scatter_ctrl #(
    .DATA(32), .IN(8), .OUT(16), .ACT(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_num(in_num),
    .in_ready(in_ready), .slot_free(slot_free), .stall(stall), .flush(flush),
    .offset(offset), .sel(sel), .issue_num(issue_num), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [3:0]  num;
    logic [15:0] sf;
    logic        st;
    logic        fl;
    logic [15:0] e_sel;
    logic [3:0]  e_iss;
    logic        e_rdy;
    logic [2:0]  e_ofs;
    logic        e_busy;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [15:0] e_sel, input logic [3:0] e_iss,
                           input logic e_rdy, input logic [2:0] e_ofs, input logic e_busy);
    check("sel", idx, 32'(sel), 32'(e_sel));
    check("issue_num", idx, 32'(issue_num), 32'(e_iss));
    check("in_ready", idx, 32'(in_ready), 32'(e_rdy));
    check("offset", idx, 32'(offset), 32'(e_ofs));
    check("busy", idx, 32'(busy), 32'(e_busy));
  endtask

  // Reference model state
  int          m_off;
  int          cur_num;
  bit          need_new;
  int          m_num, m_avail, m_free, m_take;
  bit          m_go, m_rdy;
  logic [15:0] m_sel, m_rest;
  logic [31:0] rnd;
  int          cyc;
  bit          seen;

  initial begin
    compared   = 0;
    mismatched = 0;
    reset = 1'b1; in_valid = 1'b0; in_num = 4'd0; slot_free = 16'h0000;
    stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);

    //         rst   iv    num    sf        st    fl    e_sel     iss   rdy   ofs   busy
    vecs[0]  = '{1'b1, 1'b1, 4'd3,  16'hFFFF, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 3'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'd3,  16'h0023, 1'b0, 1'b0, 16'h0023, 4'd3, 1'b1, 3'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'd0,  16'hFFFF, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 3'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'd8,  16'h000F, 1'b0, 1'b0, 16'h000F, 4'd4, 1'b0, 3'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'd8,  16'h00F0, 1'b0, 1'b0, 16'h00F0, 4'd4, 1'b1, 3'd4, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 4'd5,  16'hFFFF, 1'b0, 1'b0, 16'h001F, 4'd5, 1'b1, 3'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'd8,  16'h000F, 1'b0, 1'b0, 16'h000F, 4'd4, 1'b0, 3'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'd8,  16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 3'd4, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 4'd8,  16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 3'd4, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 4'd8,  16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 3'd4, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 4'd8,  16'hFFFF, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 3'd4, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 4'd8,  16'hFFFF, 1'b0, 1'b1, 16'h0000, 4'd0, 1'b0, 3'd4, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 4'd8,  16'hFFFF, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 3'd0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 4'd8,  16'h000F, 1'b0, 1'b0, 16'h000F, 4'd4, 1'b0, 3'd0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 4'd8,  16'hFFFF, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 3'd0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 4'd0,  16'hFFFF, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 3'd0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 4'd12, 16'hFFFF, 1'b0, 1'b0, 16'h00FF, 4'd8, 1'b1, 3'd0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 4'd8,  16'h0007, 1'b0, 1'b0, 16'h0007, 4'd3, 1'b0, 3'd0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 4'd8,  16'hFFFF, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 3'd3, 1'b1};
    vecs[20] = '{1'b0, 1'b1, 4'd8,  16'hFFFF, 1'b0, 1'b0, 16'h001F, 4'd5, 1'b1, 3'd3, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 4'd8,  16'hFFFF, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 3'd0, 1'b0};

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; in_valid = vecs[i].iv; in_num = vecs[i].num;
      slot_free = vecs[i].sf; stall = vecs[i].st; flush = vecs[i].fl;
      #1;
      check_all(i, vecs[i].e_sel, vecs[i].e_iss, vecs[i].e_rdy, vecs[i].e_ofs, vecs[i].e_busy);
    end

    // Six-element block drained one walking free slot per cycle.
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 12) begin
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b1; in_num = 4'd6; stall = 1'b0; flush = 1'b0;
      slot_free = 16'h0001 << (cyc % 16);
      #1;
      check_all(100 + cyc, 16'h0001 << (cyc % 16), 4'd1, (cyc == 5), 3'(cyc), (cyc != 0));
      seen = in_ready;
      cyc++;
    end
    check("walk_cycles", 100, 32'(cyc), 32'd6);

    // Randomized regression against the reference model.
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; #1;
    check_all(200, 16'h0000, 4'd0, 1'b0, 3'd0, 1'b0);
    m_off    = 0;
    need_new = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (need_new) begin
        cur_num  = $urandom_range(0, 15);
        need_new = 1'b0;
      end
      rnd       = $urandom;
      reset     = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      in_valid  = ($urandom_range(0, 19) != 0);
      in_num    = 4'(cur_num);
      slot_free = (rnd[3:0] == 4'd0) ? 16'h0000 : (rnd[31:16] & 16'($urandom));

      if (reset) begin
        m_sel = 16'h0000; m_take = 0; m_rdy = 1'b0;
      end else begin
        m_num   = (cur_num > 8) ? 8 : cur_num;
        m_avail = m_num - m_off;
        m_free  = $countones(slot_free);
        m_go    = in_valid && !stall && !flush;
        m_take  = m_go ? ((m_avail < m_free) ? m_avail : m_free) : 0;
        m_sel   = 16'h0000;
        m_rest  = slot_free;
        for (int t = 0; t < m_take; t++) begin
          m_sel  = m_sel | (m_rest & (~m_rest + 16'd1));
          m_rest = m_rest & (m_rest - 16'd1);
        end
        m_rdy = m_go && (m_off + m_take == m_num);
      end
      #1;
      check_all(1000 + c, m_sel, 4'(m_take), m_rdy, reset ? 3'd0 : 3'(m_off),
                reset ? 1'b0 : (m_off != 0));

      if (reset || flush || m_rdy) begin
        m_off    = 0;
        need_new = 1'b1;
      end else begin
        m_off = m_off + m_take;
      end
    end

    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; stall = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
